sr_rf_scoreboard: RTL and testbench
===================================

// Module: sr_rf_scoreboard
// PURPOSE
//  Parametrised register file with a per-register pending-write scoreboard for the pipelined core.
//  Decode claims a destination at issue; write-back releases it; read ports report busy for stall control.
//  Replaces the plain 3-port register file. Adds N read ports, hazard tracking, flush and optional WB bypass.
// PARAMETERS
//  XLEN    32   data width of each register
//  NREG    32   number of architectural registers; x0 is hard-wired zero
//  NRD     2    number of combinational read ports, debug port excluded
//  MAXPEND 3    max outstanding writes per register; counter width CW = $clog2(MAXPEND+1)
//  AW      $clog2(NREG)  register address width (localparam)
// PORTS
//  clk       in   1         core clock, rising edge
//  rst_n     in   1         asynchronous active-low reset
//  dbg_addr  in   AW        debug read address
//  dbg_data  out  XLEN      debug read data; 0 when dbg_addr==0
//  rd_addr   in   NRD*AW    read addresses, port i at [i*AW +: AW]
//  rd_data   out  NRD*XLEN  read data, port i at [i*XLEN +: XLEN]
//  rd_busy   out  NRD       port i source has a pending write; consumer must stall
//  iss_vld   in   1         issue request claiming destination iss_rd
//  iss_rd    in   AW        destination register of the issuing instruction
//  iss_ok    out  1         issue accepted this cycle (combinational)
//  wb_vld    in   1         write-back valid
//  wb_addr   in   AW        write-back register
//  wb_data   in   XLEN      write-back data
//  flush     in   1         drop all pending claims (pipeline kill)
//  busy_any  out  1         OR of all pending counters != 0
//  err       out  1         sticky: write-back to a register with pending==0
// BEHAVIOUR
//  - Reset (async, rst_n=0): all pending counters=0, err=0. busy_any=0, rd_busy=0 and iss_ok=iss_vld follow.
//    Storage array is not reset. Reads of a never-written reg are X, except x0, which is always 0.
//  - Reads are combinational, zero latency: rd_data[i]=rf[rd_addr[i]], or 0 for addr 0.
//  - rd_busy[i] = pend[rd_addr[i]]!=0; always 0 for addr 0.
//  - Write: on a clk edge with wb_vld && wb_addr!=0, rf[wb_addr]<=wb_data. Writes to x0 are dropped, pend untouched.
//  - Issue: iss_ok = iss_vld && !flush && (iss_rd==0 || pend[iss_rd]!=MAXPEND).
//    iss_ok && iss_rd!=0 increments pend[iss_rd] at the edge. A refused issue has no side effect.
//  - Release: wb_vld && wb_addr!=0 decrements pend[wb_addr] if >0.
//    If pend==0, the counter stays 0 and err<=1 (sticky until reset). err is not cleared by flush.
//  - Same register issued and released in one cycle: net counter unchanged.
//    The saturation check uses the pre-edge value, so issue at MAXPEND is refused even with a coincident WB.
//  - Flush: at the edge all counters<=0; a coincident issue is refused. A coincident WB still writes data,
//    and a WB to a reg whose pend==0 before the flush edge still sets err (pre-edge value).
//  - Read-during-write: without bypass, rd_data shows the old value until the edge.
//  - No FSM; state is NREG-1 saturating up/down counters plus err and storage.
// CONFIGURATION
//  SR_RF_BYPASS_EN defined:
//    - WB-to-read bypass on every read port.
//    - If wb_vld && wb_addr==rd_addr[i]!=0, then rd_data[i]=wb_data.
//    - If additionally pend[rd_addr[i]]==1, then rd_busy[i]=0 in that cycle, saving one stall cycle.
//    - Same bypass applies to dbg_data.
//  SR_RF_BYPASS_EN undefined: no bypass; rd_busy drops the cycle after the releasing WB edge.
// STRUCTURE
//  - Package sr_rf_pkg: CW computation function, typedef pend_t (logic [CW-1:0]), helper to slice packed ports.
//  - Sub-module sr_rf_pend_ctr: one saturating up/down counter with inc, dec, clr, sat, underflow.
//    Instantiated in a generate loop for regs 1..NREG-1.
//  - Top: storage array, read muxes, bypass logic (macro-guarded), err and busy_any reduction.
// TESTING
//  1. Reset, then WB x5=0x1234 with no issue -> err=1; rf[5]=0x1234; rd_data for x5=0x1234.
//  2. Issue x3, then read x3 -> rd_busy=1 for 1+ cycles; WB x3=0xAA -> next cycle rd_busy=0, rd_data=0xAA.
//     With the bypass macro: rd_busy=0 and rd_data=0xAA in the WB cycle itself.
//  3. Issue x7 three times (MAXPEND=3) -> 4th issue gives iss_ok=0.
//     Issue + WB x7 in one cycle -> iss_ok=0, pend=2. Two more WBs -> pend=0, err=0.
//  4. Issue x0, WB x0=0xFFFF -> iss_ok=1, rd_busy=0, rd_data(x0)=0, dbg_data(x0)=0, err=0.
//  5. Issue x1,x2; flush with coincident iss_vld(x4) and WB x1=0x55 -> iss_ok=0, busy_any=0 after edge,
//     rf[1]=0x55, err=0. A later WB x2 sets err=1.
//  6. Assert rst_n low mid-sequence with pend[9]=2 -> busy_any=0 and err=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/sr_rf_pkg.sv
// rtl/sr_rf_pkg.sv - shared helpers and types for the scoreboarded register file
package sr_rf_pkg;

  function automatic int calc_cw(input int maxpend);
    return $clog2(maxpend + 1);
  endfunction

  localparam int DEF_MAXPEND = 3;
  localparam int DEF_CW      = calc_cw(DEF_MAXPEND);

  typedef logic [DEF_CW-1:0] pend_t;

  // Low bit index of lane idx in a packed bus of w-bit lanes.
  function automatic int slice_lo(input int idx, input int w);
    return idx * w;
  endfunction

endpackage

// File: rtl/sr_rf_pend_ctr.sv
// rtl/sr_rf_pend_ctr.sv - saturating pending-write counter for one register
module sr_rf_pend_ctr
  import sr_rf_pkg::*;
#(
  parameter int MAXPEND = 3,
  parameter int CW      = calc_cw(MAXPEND)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt,
  output logic          o_sat,
  output logic          o_underflow
);

  logic [CW-1:0] r_cnt;
  logic          w_inc;
  logic          w_dec;

  assign o_sat       = (r_cnt == CW'(MAXPEND));
  assign o_underflow = i_dec && (r_cnt == '0);
  assign w_inc       = i_inc && !o_sat;
  // A release against an empty counter is reported, not applied.
  assign w_dec       = i_dec && (r_cnt != '0);
  assign o_cnt       = r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + CW'(1);
    end else if (w_dec && !w_inc) begin
      r_cnt <= r_cnt - CW'(1);
    end
  end

endmodule

// File: rtl/sr_rf_scoreboard.sv
// rtl/sr_rf_scoreboard.sv - register file with per-register pending-write scoreboard
// Optional WB-to-read bypass on all read ports and debug port: SR_RF_BYPASS_EN.
module sr_rf_scoreboard
  import sr_rf_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int NREG    = 32,
  parameter int NRD     = 2,
  parameter int MAXPEND = 3,
  localparam int AW     = $clog2(NREG),
  localparam int CW     = calc_cw(MAXPEND)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [AW-1:0]       dbg_addr,
  output logic [XLEN-1:0]     dbg_data,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  output logic [NRD-1:0]      rd_busy,
  input  logic                iss_vld,
  input  logic [AW-1:0]       iss_rd,
  output logic                iss_ok,
  input  logic                wb_vld,
  input  logic [AW-1:0]       wb_addr,
  input  logic [XLEN-1:0]     wb_data,
  input  logic                flush,
  output logic                busy_any,
  output logic                err
);

  logic [XLEN-1:0]         r_rf [NREG];
  logic                    r_err;
  logic [NREG-1:0][CW-1:0] w_pend;
  logic [NREG-1:0]         w_sat;
  logic [NREG-1:0]         w_uf;
  logic [NREG-1:0]         w_nz;
  logic                    w_iss_ok;
  logic                    w_wb_en;

  assign w_wb_en  = wb_vld && (wb_addr != '0);
  assign w_iss_ok = iss_vld && !flush && ((iss_rd == '0) || !w_sat[iss_rd]);
  assign iss_ok   = w_iss_ok;

  always_ff @(posedge clk) begin
    if (w_wb_en) begin
      r_rf[wb_addr] <= wb_data;
    end
  end

  assign w_pend[0] = '0;
  assign w_sat[0]  = 1'b0;
  assign w_uf[0]   = 1'b0;
  assign w_nz[0]   = 1'b0;

  // x0 has no counter; every other register tracks its own claims.
  for (genvar g = 1; g < NREG; g++) begin : g_ctr
    logic w_inc;
    logic w_dec;
    assign w_inc = w_iss_ok && (iss_rd == AW'(g));
    assign w_dec = wb_vld && (wb_addr == AW'(g));
    sr_rf_pend_ctr #(
      .MAXPEND (MAXPEND),
      .CW      (CW)
    ) u_ctr (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_inc       (w_inc),
      .i_dec       (w_dec),
      .i_clr       (flush),
      .o_cnt       (w_pend[g]),
      .o_sat       (w_sat[g]),
      .o_underflow (w_uf[g])
    );
    assign w_nz[g] = |w_pend[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (|w_uf) begin
      r_err <= 1'b1;
    end
  end

  assign err      = r_err;
  assign busy_any = |w_nz;

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   w_ra;
    logic [XLEN-1:0] w_arr;
    assign w_ra  = rd_addr[slice_lo(i, AW) +: AW];
    assign w_arr = (w_ra == '0) ? '0 : r_rf[w_ra];
`ifdef SR_RF_BYPASS_EN
    logic w_hit;
    assign w_hit = w_wb_en && (wb_addr == w_ra);
    assign rd_data[slice_lo(i, XLEN) +: XLEN] = w_hit ? wb_data : w_arr;
    // A WB that retires the last claim frees the consumer in the same cycle.
    assign rd_busy[i] = w_nz[w_ra] && !(w_hit && (w_pend[w_ra] == CW'(1)));
`else
    assign rd_data[slice_lo(i, XLEN) +: XLEN] = w_arr;
    assign rd_busy[i] = w_nz[w_ra];
`endif
  end

  logic [XLEN-1:0] w_dbg_arr;
  assign w_dbg_arr = (dbg_addr == '0) ? '0 : r_rf[dbg_addr];
`ifdef SR_RF_BYPASS_EN
  assign dbg_data = (w_wb_en && (wb_addr == dbg_addr)) ? wb_data : w_dbg_arr;
`else
  assign dbg_data = w_dbg_arr;
`endif

endmodule

// File: tb/tb_sr_rf_scoreboard.sv
// tb/tb_sr_rf_scoreboard.sv - self-checking bench for sr_rf_scoreboard
module tb_sr_rf_scoreboard;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int NRD  = 2;
  localparam int AW   = 5;
`ifdef SR_RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n;
  logic [AW-1:0]       dbg_addr;
  logic [XLEN-1:0]     dbg_data;
  logic [NRD*AW-1:0]   rd_addr;
  logic [NRD*XLEN-1:0] rd_data;
  logic [NRD-1:0]      rd_busy;
  logic                iss_vld;
  logic [AW-1:0]       iss_rd;
  logic                iss_ok;
  logic                wb_vld;
  logic [AW-1:0]       wb_addr;
  logic [XLEN-1:0]     wb_data;
  logic                flush;
  logic                busy_any;
  logic                err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sr_rf_scoreboard dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .iss_vld  (iss_vld),
    .iss_rd   (iss_rd),
    .iss_ok   (iss_ok),
    .wb_vld   (wb_vld),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .flush    (flush),
    .busy_any (busy_any),
    .err      (err)
  );

  typedef struct {
    logic        rst;
    logic        iv;
    logic [4:0]  ird;
    logic        wv;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        fl;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic        e_ok;
    logic        e_any;
    logic        e_err;
    logic        e_b0;
    logic        e_b1;
    logic        cd;
    logic [31:0] e_d;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic rst, input logic iv, input logic [4:0] ird,
                              input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                              input logic fl, input logic [4:0] a0, input logic [4:0] a1,
                              input logic e_ok, input logic e_any, input logic e_err,
                              input logic e_b0, input logic e_b1, input logic cd,
                              input logic [31:0] e_d);
    vec_t v;
    v.rst = rst; v.iv = iv; v.ird = ird; v.wv = wv; v.wa = wa; v.wd = wd; v.fl = fl;
    v.a0 = a0; v.a1 = a1; v.e_ok = e_ok; v.e_any = e_any; v.e_err = e_err;
    v.e_b0 = e_b0; v.e_b1 = e_b1; v.cd = cd; v.e_d = e_d;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic set_idle();
    iss_vld = 1'b0; iss_rd = '0; wb_vld = 1'b0; wb_addr = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference model state
  int          m_pend [NREG];
  logic [31:0] m_rf   [NREG];
  bit          m_err;

  function automatic logic [31:0] m_data(input int a);
    if (a == 0) return 32'h0;
    if (BYP && wb_vld && int'(wb_addr) == a) return wb_data;
    return m_rf[a];
  endfunction

  function automatic logic m_busy(input int a);
    if (a == 0 || m_pend[a] == 0) return 1'b0;
    if (BYP && wb_vld && int'(wb_addr) == a && m_pend[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic m_any();
    for (int r = 0; r < NREG; r++) if (m_pend[r] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic m_clear();
    for (int r = 0; r < NREG; r++) m_pend[r] = 0;
    m_err = 1'b0;
  endtask

  task automatic m_edge(input logic ok);
    int  wa;
    bit  rel;
    wa  = int'(wb_addr);
    rel = wb_vld && wa != 0;
    if (rel) begin
      m_rf[wa] = wb_data;
      if (m_pend[wa] == 0) m_err = 1'b1;
    end
    if (flush) begin
      for (int r = 0; r < NREG; r++) m_pend[r] = 0;
    end else begin
      int pre_w;
      pre_w = rel ? m_pend[wa] : 0;
      if (ok && iss_rd != 0) m_pend[iss_rd] = m_pend[iss_rd] + 1;
      if (rel && pre_w > 0) m_pend[wa] = m_pend[wa] - 1;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    set_idle();
    dbg_addr = '0;
    rd_addr  = '0;

    // Reset state, with an issue request held during reset
    iss_vld = 1'b1; iss_rd = 5'd5;
    #3;
    chk("rst_busy_any", {31'b0, busy_any}, 32'h0);
    chk("rst_err", {31'b0, err}, 32'h0);
    chk("rst_rd_busy", {30'b0, rd_busy}, 32'h0);
    chk("rst_iss_ok", {31'b0, iss_ok}, 32'h1);
    chk("rst_dbg_x0", dbg_data, 32'h0);
    set_idle();
    @(negedge clk);
    rst_n = 1'b1;

    // Directed table
    vq.push_back(mk(1,0,0,1,5,32'h1234,0,5,0, 0,0,1,0,0,1,32'h1234));
    vq.push_back(mk(1,1,3,0,0,0,0,3,5,        1,1,0,1,0,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,3,0,        0,1,0,1,0,0,0));
    vq.push_back(mk(0,0,0,1,3,32'hAA,0,3,0,   0,0,0,0,0,1,32'hAA));
    vq.push_back(mk(0,1,7,0,0,0,0,7,3,        1,1,0,1,0,0,0));
    vq.push_back(mk(0,1,7,0,0,0,0,7,3,        1,1,0,1,0,0,0));
    vq.push_back(mk(0,1,7,0,0,0,0,7,3,        1,1,0,1,0,0,0));
    vq.push_back(mk(0,1,7,0,0,0,0,7,3,        0,1,0,1,0,0,0));
    vq.push_back(mk(0,1,7,1,7,32'h77,0,7,3,   0,1,0,1,0,1,32'h77));
    vq.push_back(mk(0,0,0,1,7,32'h78,0,7,3,   0,1,0,1,0,1,32'h78));
    vq.push_back(mk(0,0,0,1,7,32'h79,0,7,3,   0,0,0,0,0,1,32'h79));
    vq.push_back(mk(0,1,0,1,0,32'hFFFF,0,0,0, 1,0,0,0,0,1,32'h0));
    vq.push_back(mk(0,1,1,0,0,0,0,1,2,        1,1,0,1,0,0,0));
    vq.push_back(mk(0,1,2,0,0,0,0,1,2,        1,1,0,1,1,0,0));
    vq.push_back(mk(0,1,4,1,1,32'h55,1,1,2,   0,0,0,0,0,1,32'h55));
    vq.push_back(mk(0,0,0,1,2,32'h22,0,2,1,   0,0,1,0,0,1,32'h22));
    vq.push_back(mk(1,0,0,1,6,32'h66,1,6,0,   0,0,1,0,0,1,32'h66));
    vq.push_back(mk(0,1,9,0,0,0,0,9,0,        1,1,1,1,0,0,0));
    vq.push_back(mk(0,1,9,1,9,32'h99,0,9,0,   1,1,1,1,0,1,32'h99));
    vq.push_back(mk(0,0,0,1,9,32'h9A,0,9,0,   0,0,1,0,0,1,32'h9A));

    foreach (vq[k]) begin
      if (vq[k].rst) do_reset();
      @(posedge clk); #1;
      iss_vld = vq[k].iv; iss_rd = vq[k].ird;
      wb_vld = vq[k].wv; wb_addr = vq[k].wa; wb_data = vq[k].wd; flush = vq[k].fl;
      rd_addr = {vq[k].a1, vq[k].a0};
      dbg_addr = vq[k].a0;
      #1;
      chk($sformatf("v%0d_iss_ok", k), {31'b0, iss_ok}, {31'b0, vq[k].e_ok});
      @(posedge clk); #1;
      set_idle();
      #1;
      chk($sformatf("v%0d_busy_any", k), {31'b0, busy_any}, {31'b0, vq[k].e_any});
      chk($sformatf("v%0d_err", k), {31'b0, err}, {31'b0, vq[k].e_err});
      chk($sformatf("v%0d_busy0", k), {31'b0, rd_busy[0]}, {31'b0, vq[k].e_b0});
      chk($sformatf("v%0d_busy1", k), {31'b0, rd_busy[1]}, {31'b0, vq[k].e_b1});
      if (vq[k].cd) begin
        chk($sformatf("v%0d_rd0", k), rd_data[31:0], vq[k].e_d);
        chk($sformatf("v%0d_dbg", k), dbg_data, vq[k].e_d);
      end
    end

    // Asynchronous reset mid-sequence with pend[9]=2 and err set
    do_reset();
    @(posedge clk); #1;
    wb_vld = 1'b1; wb_addr = 5'd10; wb_data = 32'h10;
    @(posedge clk); #1;
    set_idle(); iss_vld = 1'b1; iss_rd = 5'd9;
    @(posedge clk); #1;
    @(posedge clk); #1;
    set_idle(); rd_addr = {5'd0, 5'd9};
    #1;
    chk("ar_pre_busy_any", {31'b0, busy_any}, 32'h1);
    chk("ar_pre_err", {31'b0, err}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("ar_busy_any", {31'b0, busy_any}, 32'h0);
    chk("ar_err", {31'b0, err}, 32'h0);
    chk("ar_rd_busy", {31'b0, rd_busy[0]}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Read-during-write on x3 (holds 0xAA) with one pending claim
    @(posedge clk); #1;
    iss_vld = 1'b1; iss_rd = 5'd3;
    @(posedge clk); #1;
    set_idle();
    wb_vld = 1'b1; wb_addr = 5'd3; wb_data = 32'hBB;
    rd_addr = {5'd0, 5'd3}; dbg_addr = 5'd3;
    #1;
    chk("rdw_busy", {31'b0, rd_busy[0]}, BYP ? 32'h0 : 32'h1);
    chk("rdw_data", rd_data[31:0], BYP ? 32'hBB : 32'hAA);
    chk("rdw_dbg", dbg_data, BYP ? 32'hBB : 32'hAA);
    @(posedge clk); #1;
    set_idle();
    #1;
    chk("rdw_post_busy", {31'b0, rd_busy[0]}, 32'h0);
    chk("rdw_post_data", rd_data[31:0], 32'hBB);

    // Randomized run against the reference model
    do_reset();
    for (int r = 1; r < NREG; r++) begin
      @(posedge clk); #1;
      wb_vld = 1'b1; wb_addr = AW'(r); wb_data = $urandom;
      m_rf[r] = wb_data;
    end
    @(posedge clk); #1;
    set_idle();
    do_reset();
    m_clear();
    m_rf[0] = 32'h0;

    for (int c = 0; c < 2000; c++) begin
      logic ok_exp;
      @(posedge clk); #1;
      iss_vld = ($urandom_range(0, 1) == 1);
      iss_rd  = AW'($urandom_range(0, 7));
      wb_vld  = ($urandom_range(0, 1) == 1);
      wb_addr = AW'($urandom_range(0, 7));
      wb_data = $urandom;
      flush   = ($urandom_range(0, 31) == 0);
      rd_addr = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      dbg_addr = AW'($urandom_range(0, 7));
      #1;
      ok_exp = iss_vld && !flush && (iss_rd == 0 || m_pend[iss_rd] != 3);
      chk("rnd_iss_ok", {31'b0, iss_ok}, {31'b0, ok_exp});
      chk("rnd_busy_any", {31'b0, busy_any}, {31'b0, m_any()});
      chk("rnd_err", {31'b0, err}, {31'b0, m_err});
      for (int p = 0; p < NRD; p++) begin
        chk($sformatf("rnd_rd_data%0d", p), rd_data[p*XLEN +: XLEN], m_data(int'(rd_addr[p*AW +: AW])));
        chk($sformatf("rnd_rd_busy%0d", p), {31'b0, rd_busy[p]}, {31'b0, m_busy(int'(rd_addr[p*AW +: AW]))});
      end
      chk("rnd_dbg", dbg_data, m_data(int'(dbg_addr)));
      m_edge(ok_exp);
    end

    set_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
